juiz_ritmo: RTL
===============

JUIZ_RITMO -- requirements
Module: juiz_ritmo

Interface
REQ-001 SHALL have parameter NOTAS, default 13: number of note buttons; expected note arrives one-hot.
REQ-002 SHALL have parameter TAM_MUSICA, default 16: notes per song.
REQ-003 SHALL have parameter TICKS_BEAT, default 25000000: clock cycles per beat.
REQ-004 SHALL have parameter JANELA, default 5000000: ticks from note start during which a press counts as on time; 1 <= JANELA <= TICKS_BEAT.
REQ-005 SHALL have parameter MAX_ERROS, default 3: misses that end the game.
REQ-006 SHALL have parameter DUR_W, default 2: width of the note-duration field, in beats.
REQ-007 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port iniciar, input, 1: start or restart pulse.
REQ-010 SHALL have port botoes, input, NOTAS: player buttons, already synchronised.
REQ-011 SHALL have port nota_mem, input, NOTAS: expected note (one-hot), valid 1 cycle after endereco changes.
REQ-012 SHALL have port dur_mem, input, DUR_W: note duration in beats, same timing as nota_mem.
REQ-013 SHALL have port endereco, output, $clog2(TAM_MUSICA): song memory address.
REQ-014 SHALL have port pontos, output, $clog2(TAM_MUSICA+1): hits so far.
REQ-015 SHALL have port erros, output, $clog2(MAX_ERROS+1): misses so far.
REQ-016 SHALL have port vez_jogador, output, 1: high in ESPERA.
REQ-017 SHALL have port acerto_pulso, output, 1: one-cycle hit strobe.
REQ-018 SHALL have port erro_pulso, output, 1: one-cycle miss strobe.
REQ-019 SHALL have port ganhou, output, 1: song completed.
REQ-020 SHALL have port perdeu, output, 1: miss limit reached.
REQ-021 SHALL have port db_estado, output, 3: state encoding.

Function
REQ-022 SHALL implement states IDLE=0, CARREGA=1, ESPERA=2, AVALIA=3, PROXIMA=4, GANHOU=5, PERDEU=6.
REQ-023 SHALL go IDLE->CARREGA on iniciar, clearing endereco, pontos, erros.
REQ-024 SHALL stay in CARREGA exactly 1 cycle (memory latency), then enter ESPERA with tick counter=0 and flags avaliado=0, acertou=0.
REQ-025 SHALL, in ESPERA, increment tick each cycle; note length L = max(dur_mem,1)*TICKS_BEAT ticks, with dur_mem sampled on ESPERA entry.
REQ-026 SHALL detect a press edge when botoes!=0 this cycle and botoes==0 the previous cycle (edge register cleared in CARREGA); only the first edge per note is evaluated (sets avaliado).
REQ-027 SHALL set acertou on that first edge iff tick<JANELA and botoes==nota_mem exactly; chords or wrong notes are misses.
REQ-028 SHALL, at tick==L-1, go to AVALIA (1 cycle): pontos+1 and acerto_pulso=1 if acertou; otherwise erros+1 and erro_pulso=1 (including no press).
REQ-029 SHALL, after AVALIA, go to PERDEU if erros==MAX_ERROS; else GANHOU if endereco==TAM_MUSICA-1; else PROXIMA.
REQ-030 SHALL, in PROXIMA (1 cycle), increment endereco, then enter CARREGA.
REQ-031 SHALL hold GANHOU/PERDEU with their output high until iniciar, which enters CARREGA with counters cleared.
REQ-032 SHALL ignore iniciar in CARREGA, ESPERA, AVALIA, PROXIMA.
REQ-033 SHALL saturate pontos at TAM_MUSICA and erros at MAX_ERROS.
REQ-034 SHALL drive all outputs from registers or the state decode, with no combinational path from botoes.

Reset
REQ-035 SHALL, on reset=0 at any time, mid-note included, immediately enter IDLE with endereco=0, pontos=0, erros=0, tick=0, all strobes and flags 0, db_estado=0.
REQ-036 SHALL resume only on the first rising clock edge after reset returns high.

Verification (NOTAS=4, TAM_MUSICA=4, TICKS_BEAT=8, JANELA=3, MAX_ERROS=2, DUR_W=2)
REQ-037 SHALL cover a perfect song: dur_mem=1, correct button pressed at tick 1 of all 4 notes -> acerto_pulso x4, pontos=4, ganhou=1, erros=0.
REQ-038 SHALL cover a late press: correct note at tick 3 -> erro_pulso at tick 7+1, erros=1, pontos unchanged.
REQ-039 SHALL cover two misses (wrong note 4'b0010 vs 4'b0001, then no press) -> perdeu=1 after the 2nd AVALIA, endereco=1.
REQ-040 SHALL cover duration and re-press: dur_mem=2 -> ESPERA lasts 16 cycles; a second press at tick 10 is ignored, so a hit stays a hit.
REQ-041 SHALL cover reset mid-ESPERA at tick 4 -> db_estado=0 and all counters 0 asynchronously; a new iniciar restarts at endereco=0.
REQ-042 SHALL cover iniciar asserted in ESPERA -> no effect; iniciar in GANHOU -> CARREGA with pontos=0.

Source files
------------

// File: rtl/juiz_ritmo.sv
// Rhythm-game judge: steps through a song, times each player press against the expected note, scores hits/misses.
// One cycle of memory latency per note; AVALIA/PROXIMA are single-cycle; no backpressure, the song runs at its own tempo.
module juiz_ritmo #(
    parameter int NOTAS      = 13,
    parameter int TAM_MUSICA = 16,
    parameter int TICKS_BEAT = 25000000,
    parameter int JANELA     = 5000000,
    parameter int MAX_ERROS  = 3,
    parameter int DUR_W      = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              iniciar,
    input  logic [NOTAS-1:0]                  botoes,
    input  logic [NOTAS-1:0]                  nota_mem,
    input  logic [DUR_W-1:0]                  dur_mem,
    output logic [$clog2(TAM_MUSICA)-1:0]     endereco,
    output logic [$clog2(TAM_MUSICA+1)-1:0]   pontos,
    output logic [$clog2(MAX_ERROS+1)-1:0]    erros,
    output logic                              vez_jogador,
    output logic                              acerto_pulso,
    output logic                              erro_pulso,
    output logic                              ganhou,
    output logic                              perdeu,
    output logic [2:0]                        db_estado
);

    localparam int EW   = $clog2(TAM_MUSICA);
    localparam int PW   = $clog2(TAM_MUSICA + 1);
    localparam int ERW  = $clog2(MAX_ERROS + 1);
    localparam int LMAX = ((1 << DUR_W) - 1) * TICKS_BEAT;
    localparam int TW   = $clog2(LMAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CARREGA = 3'd1,
        ESPERA  = 3'd2,
        AVALIA  = 3'd3,
        PROXIMA = 3'd4,
        GANHOU  = 3'd5,
        PERDEU  = 3'd6
    } estado_t;

    estado_t         estado;
    logic [TW-1:0]   tick;
    logic [TW-1:0]   len_q;
    logic            avaliado;
    logic            acertou;
    logic            botoes_ant;

    logic [TW-1:0]   dur_ext;
    logic [TW-1:0]   len_calc;
    logic [TW-1:0]   len_atual;
    logic            fim_nota;
    logic            borda;
    logic            acerto_agora;
    logic            acertou_final;

    // Memory data becomes valid on the first ESPERA cycle, so the note length
    // is taken straight from dur_mem at tick 0 and from the latched copy after.
    always_comb begin
        dur_ext = TW'(dur_mem);
        if (dur_mem == '0) begin
            dur_ext = TW'(1);
        end
        len_calc = dur_ext * TW'(TICKS_BEAT);
    end

    assign len_atual     = (tick == '0) ? len_calc : len_q;
    assign fim_nota      = (tick == (len_atual - TW'(1)));
    assign borda         = (botoes != '0) && !botoes_ant;
    assign acerto_agora  = (tick < TW'(JANELA)) && (botoes == nota_mem);
    assign acertou_final = avaliado ? acertou : (borda && acerto_agora);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= IDLE;
            endereco     <= '0;
            pontos       <= '0;
            erros        <= '0;
            tick         <= '0;
            len_q        <= '0;
            avaliado     <= 1'b0;
            acertou      <= 1'b0;
            botoes_ant   <= 1'b0;
            acerto_pulso <= 1'b0;
            erro_pulso   <= 1'b0;
        end else begin
            acerto_pulso <= 1'b0;
            erro_pulso   <= 1'b0;
            botoes_ant   <= (botoes != '0);

            case (estado)
                IDLE: begin
                    if (iniciar) begin
                        estado   <= CARREGA;
                        endereco <= '0;
                        pontos   <= '0;
                        erros    <= '0;
                    end
                end

                CARREGA: begin
                    tick       <= '0;
                    avaliado   <= 1'b0;
                    acertou    <= 1'b0;
                    botoes_ant <= 1'b0;
                    estado     <= ESPERA;
                end

                ESPERA: begin
                    tick <= tick + TW'(1);
                    if (tick == '0) begin
                        len_q <= len_calc;
                    end
                    // Only the first press of a note is judged; later ones are ignored.
                    if (borda && !avaliado) begin
                        avaliado <= 1'b1;
                        acertou  <= acerto_agora;
                    end
                    if (fim_nota) begin
                        estado <= AVALIA;
                        if (acertou_final) begin
                            acerto_pulso <= 1'b1;
                            if (pontos != PW'(TAM_MUSICA)) begin
                                pontos <= pontos + PW'(1);
                            end
                        end else begin
                            erro_pulso <= 1'b1;
                            if (erros != ERW'(MAX_ERROS)) begin
                                erros <= erros + ERW'(1);
                            end
                        end
                    end
                end

                AVALIA: begin
                    if (erros == ERW'(MAX_ERROS)) begin
                        estado <= PERDEU;
                    end else if (endereco == EW'(TAM_MUSICA - 1)) begin
                        estado <= GANHOU;
                    end else begin
                        estado <= PROXIMA;
                    end
                end

                PROXIMA: begin
                    endereco <= endereco + EW'(1);
                    estado   <= CARREGA;
                end

                GANHOU, PERDEU: begin
                    if (iniciar) begin
                        estado   <= CARREGA;
                        endereco <= '0;
                        pontos   <= '0;
                        erros    <= '0;
                    end
                end

                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

    assign vez_jogador = (estado == ESPERA);
    assign ganhou      = (estado == GANHOU);
    assign perdeu      = (estado == PERDEU);
    assign db_estado   = estado;

endmodule
